// File: rtl/sub_arbiter.sv
// Shares one 3-lane subtract unit between two requesters, round-robin, and routes results back by issue-order tags.
// Latency: issue is combinational (0 cycles); results are steered to their requester in the cycle they are popped.
// Backpressure: a full tag queue or a non-RUN state withholds offers; a full destination stalls the return path (head-of-line).
module sub_arbiter #(
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][31:0]           req0_x,
  input  logic [2:0][31:0]           req0_y,
  input  logic                       req0_empty,
  output logic                       req0_rd_en,
  input  logic [2:0][31:0]           req1_x,
  input  logic [2:0][31:0]           req1_y,
  input  logic                       req1_empty,
  output logic                       req1_rd_en,
  output logic [2:0][31:0]           sub_x,
  output logic [2:0][31:0]           sub_y,
  output logic                       sub_in_empty,
  input  logic                       sub_in_rd_en,
  input  logic [2:0][31:0]           sub_out,
  input  logic                       sub_out_empty,
  output logic                       sub_out_rd_en,
  output logic [2:0][31:0]           res0_dout,
  output logic                       res0_wr_en,
  input  logic                       res0_full,
  output logic [2:0][31:0]           res1_dout,
  output logic                       res1_wr_en,
  input  logic                       res1_full,
  input  logic                       flush,
  output logic                       idle,
  output logic [$clog2(TAG_DEPTH):0] outstanding
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 idle_q, idle_d;

  logic grant_vld;
  logic grant_sel;
  logic issue;
  logic ret;
  logic head_tag;
  logic head_full;

  // Round-robin grant: the favoured requester wins if it has work, otherwise the other one.
  always_comb begin
    grant_vld = !req0_empty || !req1_empty;
    grant_sel = prio_q ? !req1_empty : (req0_empty && !req1_empty);
  end

  // Issue/return handshakes and result steering; everything is gated off while reset is held.
  always_comb begin
    sub_in_empty  = !reset || !grant_vld || (count_q == FULL_CNT) || (state_q != ST_RUN);
    issue         = sub_in_rd_en && !sub_in_empty;
    req0_rd_en    = issue && !grant_sel;
    req1_rd_en    = issue && grant_sel;
    sub_x         = grant_sel ? req1_x : req0_x;
    sub_y         = grant_sel ? req1_y : req0_y;
    head_tag      = tags_q[rd_ptr_q];
    head_full     = head_tag ? res1_full : res0_full;
    // A result arriving with no tag outstanding is a protocol error; it is left in the unit.
    sub_out_rd_en = reset && !sub_out_empty && (count_q != '0) && !head_full;
    ret           = sub_out_rd_en;
    res0_wr_en    = ret && !head_tag;
    res1_wr_en    = ret && head_tag;
    res0_dout     = sub_out;
    res1_dout     = sub_out;
    outstanding   = count_q;
    idle          = idle_q;
  end

  // Tag queue, priority pointer and RUN/DRAIN/IDLE next-state logic.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    count_d  = count_q;
    state_d  = state_q;

    if (issue) begin
      tags_d[wr_ptr_q] = grant_sel;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      prio_d           = !grant_sel;
    end
    if (ret) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({issue, ret})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_RUN: begin
        // With nothing in flight and nothing issued this cycle there is nothing to drain.
        if (flush) begin
          state_d = ((count_q == '0) && !issue) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!flush) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  // State register with asynchronous active-low reset; reset drops all in-flight tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      prio_q   <= 1'b0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
    end
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: directed scenarios followed by a randomized phase.
// Reference model works on queues of operands, tags and pending results, advanced once per clock.
// The bench also plays the subtract unit and both result FIFOs.
module tb_sub_arbiter;

  localparam int DEPTH = 8;
  localparam int RUN = 0, DRAIN = 1, IDLE = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [95:0] req0_x, req0_y, req1_x, req1_y;
  logic req0_empty, req1_empty, req0_rd_en, req1_rd_en;
  logic [95:0] sub_x, sub_y, sub_out, res0_dout, res1_dout;
  logic sub_in_empty, sub_in_rd_en, sub_out_empty, sub_out_rd_en;
  logic res0_wr_en, res1_wr_en, res0_full, res1_full, flush, idle;
  logic [$clog2(DEPTH):0] outstanding;

  always #5 clock = ~clock;

  sub_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_x(req0_x), .req0_y(req0_y), .req0_empty(req0_empty), .req0_rd_en(req0_rd_en),
    .req1_x(req1_x), .req1_y(req1_y), .req1_empty(req1_empty), .req1_rd_en(req1_rd_en),
    .sub_x(sub_x), .sub_y(sub_y), .sub_in_empty(sub_in_empty), .sub_in_rd_en(sub_in_rd_en),
    .sub_out(sub_out), .sub_out_empty(sub_out_empty), .sub_out_rd_en(sub_out_rd_en),
    .res0_dout(res0_dout), .res0_wr_en(res0_wr_en), .res0_full(res0_full),
    .res1_dout(res1_dout), .res1_wr_en(res1_wr_en), .res1_full(res1_full),
    .flush(flush), .idle(idle), .outstanding(outstanding)
  );

  // Bench-side requester FIFOs, subtract unit contents and reference model state.
  logic [95:0] q0x[$], q0y[$], q1x[$], q1y[$];
  logic [95:0] unit_q[$], exp0[$], exp1[$];
  bit          tags[$];
  bit          prio;
  int          st;
  logic        hold0, hold1, unit_stall;
  int          passes, total;
  int          obs_rd0, obs_rd1, obs_wr0, obs_wr1;

  function automatic logic [95:0] sub3(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chkv(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push0(input logic [95:0] x, input logic [95:0] y);
    q0x.push_back(x); q0y.push_back(y);
  endtask

  task automatic push1(input logic [95:0] x, input logic [95:0] y);
    q1x.push_back(x); q1y.push_back(y);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    req0_empty    = (q0x.size() == 0) || hold0;
    req1_empty    = (q1x.size() == 0) || hold1;
    req0_x        = (q0x.size() != 0) ? q0x[0] : rnd96();
    req0_y        = (q0y.size() != 0) ? q0y[0] : rnd96();
    req1_x        = (q1x.size() != 0) ? q1x[0] : rnd96();
    req1_y        = (q1y.size() != 0) ? q1y[0] : rnd96();
    sub_out       = (unit_q.size() != 0) ? unit_q[0] : rnd96();
    sub_out_empty = (unit_q.size() == 0) || unit_stall;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit e_vld, e_sel, e_full, e_sie, e_issue, e_ret, e_h;
    int n;
    logic [95:0] d;
    drive();
    @(negedge clock);
    e_vld = !req0_empty || !req1_empty;
    if (!(prio ? req1_empty : req0_empty)) e_sel = prio;
    else                                   e_sel = !prio;
    e_full  = (tags.size() >= DEPTH);
    e_sie   = !reset || !e_vld || e_full || (st != RUN);
    e_issue = sub_in_rd_en && !e_sie;
    e_h     = (tags.size() != 0) ? tags[0] : 1'b0;
    e_ret   = reset && !sub_out_empty && (tags.size() != 0) && !(e_h ? res1_full : res0_full);

    chk1("sub_in_empty", sub_in_empty, e_sie);
    chk1("req0_rd_en", req0_rd_en, e_issue && !e_sel);
    chk1("req1_rd_en", req1_rd_en, e_issue && e_sel);
    if (e_vld) begin
      chkv("sub_x", sub_x, e_sel ? req1_x : req0_x);
      chkv("sub_y", sub_y, e_sel ? req1_y : req0_y);
    end else begin
      chkv("sub_x_nogrant", sub_x, req0_x);
    end
    chk1("sub_out_rd_en", sub_out_rd_en, e_ret);
    chk1("res0_wr_en", res0_wr_en, e_ret && !e_h);
    chk1("res1_wr_en", res1_wr_en, e_ret && e_h);
    chkv("res0_mirror", res0_dout, sub_out);
    chkv("res1_mirror", res1_dout, sub_out);
    chki("outstanding", int'(outstanding), tags.size());
    chk1("idle", idle, st == IDLE);
    if (e_ret) begin
      if (e_h) chkv("res1_dout", res1_dout, exp1.pop_front());
      else     chkv("res0_dout", res0_dout, exp0.pop_front());
    end
    obs_rd0 += int'(req0_rd_en);
    obs_rd1 += int'(req1_rd_en);
    obs_wr0 += int'(res0_wr_en);
    obs_wr1 += int'(res1_wr_en);

    @(posedge clock);
    if (reset) begin
      n = tags.size();
      if (e_ret) begin
        void'(tags.pop_front());
        void'(unit_q.pop_front());
      end
      if (e_issue) begin
        if (e_sel) begin
          d = sub3(q1x.pop_front(), q1y.pop_front());
          exp1.push_back(d);
        end else begin
          d = sub3(q0x.pop_front(), q0y.pop_front());
          exp0.push_back(d);
        end
        tags.push_back(e_sel);
        unit_q.push_back(d);
        prio = !e_sel;
      end
      case (st)
        RUN:     if (flush) st = (n == 0 && !e_issue) ? IDLE : DRAIN;
        DRAIN:   if (n == 0) st = IDLE;
        default: if (!flush) st = RUN;
      endcase
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    tags.delete(); unit_q.delete(); exp0.delete(); exp1.delete();
    prio = 1'b0;
    st   = RUN;
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int b0, b1, w0, w1, guard;
    passes = 0; total = 0;
    obs_rd0 = 0; obs_rd1 = 0; obs_wr0 = 0; obs_wr1 = 0;
    hold0 = 0; hold1 = 0; unit_stall = 0;
    res0_full = 0; res1_full = 0; flush = 0; sub_in_rd_en = 1;

    // Reset with a pending request and an eager unit: nothing may move.
    push0({32'hFFFFFFFE, 32'd7, 32'd5}, {32'hFFFFFFFE, 32'd10, 32'd1});
    do_reset(3);
    chki("rst_issues", obs_rd0 + obs_rd1, 0);
    chki("rst_outstanding", int'(outstanding), 0);

    // Single req0 transaction: (5,7,-2)-(1,10,-2) = (4,-3,0) on res0 only.
    b0 = obs_rd0; w0 = obs_wr0; w1 = obs_wr1;
    ticks(5);
    chki("single_rd0", obs_rd0 - b0, 1);
    chki("single_wr0", obs_wr0 - w0, 1);
    chki("single_wr1", obs_wr1 - w1, 0);

    // Data transparency at the signed boundary.
    push0({32'd1, 32'h80000000, 32'h7FFFFFFF}, {32'd2, 32'd1, 32'hFFFFFFFF});
    w0 = obs_wr0;
    ticks(4);
    chki("wrap_wr0", obs_wr0 - w0, 1);

    // Both requesters saturated: alternating issues, 8 results per port.
    for (int i = 0; i < 8; i++) begin
      push0(rnd96(), rnd96());
      push1(rnd96(), rnd96());
    end
    b0 = obs_rd0; b1 = obs_rd1; w0 = obs_wr0; w1 = obs_wr1;
    ticks(30);
    chki("rr_rd0", obs_rd0 - b0, 8);
    chki("rr_rd1", obs_rd1 - b1, 8);
    chki("rr_wr0", obs_wr0 - w0, 8);
    chki("rr_wr1", obs_wr1 - w1, 8);
    chki("rr_outstanding", int'(outstanding), 0);

    // Unit never returns: tag queue caps issues at its depth.
    unit_stall = 1;
    for (int i = 0; i < 5; i++) begin
      push0(rnd96(), rnd96());
      push1(rnd96(), rnd96());
    end
    b0 = obs_rd0; b1 = obs_rd1;
    ticks(20);
    chki("full_issues", (obs_rd0 - b0) + (obs_rd1 - b1), DEPTH);
    chki("full_outstanding", int'(outstanding), DEPTH);
    chk1("full_sub_in_empty", sub_in_empty, 1'b1);
    unit_stall = 0;
    ticks(30);
    chki("full_drained", int'(outstanding), 0);

    // Head-of-line blocking: req0 result at head with res0 full holds back req1's result.
    unit_stall = 1;
    q1x.delete(); q1y.delete();
    push0(rnd96(), rnd96());
    ticks(2);
    push1(rnd96(), rnd96());
    ticks(2);
    res0_full = 1; unit_stall = 0;
    w0 = obs_wr0; w1 = obs_wr1;
    ticks(5);
    chki("hol_wr0", obs_wr0 - w0, 0);
    chki("hol_wr1", obs_wr1 - w1, 0);
    res0_full = 0;
    ticks(1);
    chki("hol_first_wr0", obs_wr0 - w0, 1);
    chki("hol_first_wr1", obs_wr1 - w1, 0);
    ticks(1);
    chki("hol_second_wr1", obs_wr1 - w1, 1);

    // Flush with three in flight: no issue, idle one cycle after the last return, resume after release.
    unit_stall = 1;
    for (int i = 0; i < 3; i++) push0(rnd96(), rnd96());
    ticks(4);
    chki("flush_outstanding", int'(outstanding), 3);
    flush = 1;
    ticks(1);
    push0(rnd96(), rnd96());
    push0(rnd96(), rnd96());
    b0 = obs_rd0;
    ticks(4);
    chki("flush_no_issue", obs_rd0 - b0, 0);
    unit_stall = 0;
    ticks(3);
    chki("flush_drained", int'(outstanding), 0);
    chk1("flush_idle_lag", idle, 1'b0);
    ticks(1);
    chk1("flush_idle", idle, 1'b1);
    flush = 0;
    b0 = obs_rd0;
    ticks(1);
    chki("resume_wait", obs_rd0 - b0, 0);
    ticks(1);
    chki("resume_issue", obs_rd0 - b0, 1);
    ticks(10);

    // Randomized traffic, backpressure and flush toggling.
    for (int c = 0; c < 2000; c++) begin
      if (q0x.size() < 4 && $urandom_range(0, 2) == 0) push0(rnd96(), rnd96());
      if (q1x.size() < 4 && $urandom_range(0, 2) == 0) push1(rnd96(), rnd96());
      hold0        = ($urandom_range(0, 5) == 0);
      hold1        = ($urandom_range(0, 5) == 0);
      sub_in_rd_en = ($urandom_range(0, 3) != 0);
      unit_stall   = ($urandom_range(0, 3) == 0);
      res0_full    = ($urandom_range(0, 4) == 0);
      res1_full    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) flush = !flush;
      tick();
    end
    hold0 = 0; hold1 = 0; sub_in_rd_en = 1; unit_stall = 0;
    res0_full = 0; res1_full = 0; flush = 0;
    guard = 0;
    while ((tags.size() != 0 || q0x.size() != 0 || q1x.size() != 0 || st != RUN) && guard < 200) begin
      tick();
      guard++;
    end
    chk1("random_settled", guard < 200, 1'b1);
    chki("random_outstanding", int'(outstanding), 0);

    // Reset mid-operation discards in-flight tags.
    unit_stall = 1;
    for (int i = 0; i < 3; i++) push1(rnd96(), rnd96());
    ticks(4);
    chki("midrst_before", int'(outstanding), 3);
    do_reset(2);
    chki("midrst_after", int'(outstanding), 0);
    unit_stall = 0;
    ticks(20);
    chki("midrst_recovered", int'(outstanding), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
